// File: rtl/decoder_3to8_sync.sv
// -----------------------------------------------------------------------------
// decoder_3to8_sync
//
// Registered 3-to-8 line decoder with enable, driving the row-select bus of
// the 8x8 RGB LED matrix scanner. Converts a 3-bit row index into a one-hot
// row drive word.
//
// Optional feature, selected by the macro DECODER_3TO8_BLANK_EN:
//   defined   - break-before-make: every new line is preceded by BLANK_CYCLES
//               all-inactive cycles, reported on blank_o (IDLE/BLANK/DRIVE FSM)
//   undefined - pure registered decoder, BLANK_CYCLES ignored, blank_o = 0
//
// Parameters:
//   ACTIVE_HIGH  - 1: selected line = 1, others 0; 0: every bit inverted
//   BLANK_CYCLES - all-inactive cycles before a new line asserts (0..255)
//
// Ports:
//   clk_i         in   1  system clock (single clock domain)
//   rst_i         in   1  synchronous active-high reset
//   data_3bit_i   in   3  line index 0..7
//   decoder_en_i  in   1  decode enable; low forces every line inactive
//   data_8bit_o   out  8  registered line drive, bit k <-> index k
//   blank_o       out  1  high while a blanking interval is in progress
// -----------------------------------------------------------------------------
module decoder_3to8_sync #(
    parameter int ACTIVE_HIGH  = 1,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] data_3bit_i,
    input  logic       decoder_en_i,
    output logic [7:0] data_8bit_o,
    output logic       blank_o
);

    localparam logic [7:0] INACTIVE_WORD = (ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

    // An out-of-range BLANK_CYCLES elaborates this empty, clearly named
    // scope so the misconfiguration shows up in the design hierarchy.
    generate
        if (BLANK_CYCLES < 0 || BLANK_CYCLES > 255) begin : g_illegal_blank_cycles
        end
    endgenerate

    // Drive word for a given index. Unknown index values fall into the
    // default branch, which yields the inactive word in either polarity.
    function automatic logic [7:0] active_word(input logic [2:0] idx);
        logic [7:0] one_hot;
        case (idx)
            3'd0:    one_hot = 8'h01;
            3'd1:    one_hot = 8'h02;
            3'd2:    one_hot = 8'h04;
            3'd3:    one_hot = 8'h08;
            3'd4:    one_hot = 8'h10;
            3'd5:    one_hot = 8'h20;
            3'd6:    one_hot = 8'h40;
            3'd7:    one_hot = 8'h80;
            default: one_hot = 8'h00;
        endcase
        return (ACTIVE_HIGH != 0) ? one_hot : ~one_hot;
    endfunction

`ifdef DECODER_3TO8_BLANK_EN

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    // Counter value on the last blanking cycle; with no blanking the BLANK
    // state is never entered, so the value is irrelevant there.
    localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
    localparam bit         HAS_BLANK  = (BLANK_CYCLES > 0);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic [2:0] idx_reg;
    logic [7:0] data_reg;
    logic       blank_reg;

    // Priority inside each state: enable low > index change > counter expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            idx_reg   <= 3'd0;
            data_reg  <= INACTIVE_WORD;
            blank_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    data_reg  <= INACTIVE_WORD;
                    blank_reg <= 1'b0;
                    if (decoder_en_i) begin
                        idx_reg <= data_3bit_i;
                        cnt_reg <= 8'd0;
                        if (HAS_BLANK) begin
                            state_reg <= ST_BLANK;
                            blank_reg <= 1'b1;
                        end else begin
                            // Zero-length blank: behave exactly like the
                            // plain registered decoder.
                            state_reg <= ST_DRIVE;
                            data_reg  <= active_word(data_3bit_i);
                        end
                    end
                end

                ST_BLANK: begin
                    if (!decoder_en_i) begin
                        state_reg <= ST_IDLE;
                        data_reg  <= INACTIVE_WORD;
                        blank_reg <= 1'b0;
                    end else if (data_3bit_i != idx_reg) begin
                        // A new target restarts the full blanking interval.
                        idx_reg   <= data_3bit_i;
                        cnt_reg   <= 8'd0;
                        data_reg  <= INACTIVE_WORD;
                        blank_reg <= 1'b1;
                    end else if (cnt_reg == BLANK_LAST) begin
                        state_reg <= ST_DRIVE;
                        data_reg  <= active_word(idx_reg);
                        blank_reg <= 1'b0;
                    end else begin
                        cnt_reg   <= cnt_reg + 8'd1;
                        data_reg  <= INACTIVE_WORD;
                        blank_reg <= 1'b1;
                    end
                end

                ST_DRIVE: begin
                    if (!decoder_en_i) begin
                        state_reg <= ST_IDLE;
                        data_reg  <= INACTIVE_WORD;
                        blank_reg <= 1'b0;
                    end else if (data_3bit_i != idx_reg) begin
                        idx_reg <= data_3bit_i;
                        cnt_reg <= 8'd0;
                        if (HAS_BLANK) begin
                            // Break before make: drop the old line first.
                            state_reg <= ST_BLANK;
                            data_reg  <= INACTIVE_WORD;
                            blank_reg <= 1'b1;
                        end else begin
                            data_reg  <= active_word(data_3bit_i);
                            blank_reg <= 1'b0;
                        end
                    end
                    // Same index re-presented: hold the line untouched.
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 8'd0;
                    data_reg  <= INACTIVE_WORD;
                    blank_reg <= 1'b0;
                end
            endcase
        end
    end

    assign data_8bit_o = data_reg;
    assign blank_o     = blank_reg;

`else

    logic [7:0] data_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg <= INACTIVE_WORD;
        end else begin
            data_reg <= decoder_en_i ? active_word(data_3bit_i) : INACTIVE_WORD;
        end
    end

    assign data_8bit_o = data_reg;
    assign blank_o     = 1'b0;

`endif

endmodule

// File: tb/tb_decoder_3to8_sync.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8_sync
//
// Two decoders share one stimulus bus:
//   dut_a - ACTIVE_HIGH=1, default BLANK_CYCLES (2)
//   dut_b - ACTIVE_HIGH=0, BLANK_CYCLES=0, which must behave as a plain
//           registered decoder in either build
// Expected values are queued when a step's stimulus is driven and popped when
// the registered outputs are sampled, 1 time unit after the following edge.
// Build with DECODER_3TO8_BLANK_EN defined to exercise the blanking sequences.
// -----------------------------------------------------------------------------
module tb_decoder_3to8_sync;

    logic       clk;
    logic       rst;
    logic [2:0] idx;
    logic       en;
    logic [7:0] data_a;
    logic       blank_a;
    logic [7:0] data_b;
    logic       blank_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_a_q[$];
    logic       exp_blank_q[$];
    logic [7:0] exp_b_q[$];

    decoder_3to8_sync #(
        .ACTIVE_HIGH (1)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_3bit_i  (idx),
        .decoder_en_i (en),
        .data_8bit_o  (data_a),
        .blank_o      (blank_a)
    );

    decoder_3to8_sync #(
        .ACTIVE_HIGH  (0),
        .BLANK_CYCLES (0)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_3bit_i  (idx),
        .decoder_en_i (en),
        .data_8bit_o  (data_b),
        .blank_o      (blank_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [7:0] onehot(input logic [2:0] i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    // One clock step: queue expectations, drive inputs, wait for the edge,
    // then pop and compare every output.
    task automatic step(input logic r, input logic e, input logic [2:0] ix,
                        input logic [7:0] ea, input logic eb, input string tag);
        logic [7:0] ga;
        logic       gbl;
        logic [7:0] gb;
        exp_a_q.push_back(ea);
        exp_blank_q.push_back(eb);
        exp_b_q.push_back(r ? 8'hFF : (e ? ~onehot(ix) : 8'hFF));
        rst = r;
        en  = e;
        idx = ix;
        @(posedge clk);
        #1;
        ga  = exp_a_q.pop_front();
        gbl = exp_blank_q.pop_front();
        gb  = exp_b_q.pop_front();

        tests_run++;
        assert (data_a === ga) else begin
            tests_failed++;
            $error("FAIL %s data_a: observed %h expected %h", tag, data_a, ga);
        end
        tests_run++;
        assert (blank_a === gbl) else begin
            tests_failed++;
            $error("FAIL %s blank_a: observed %b expected %b", tag, blank_a, gbl);
        end
        tests_run++;
        assert (data_b === gb) else begin
            tests_failed++;
            $error("FAIL %s data_b(active-low): observed %h expected %h", tag, data_b, gb);
        end
        tests_run++;
        assert (blank_b === 1'b0) else begin
            tests_failed++;
            $error("FAIL %s blank_b: observed %b expected 0", tag, blank_b);
        end
        $display("[TB] %s rst=%b en=%b idx=%0d -> a=%h blank=%b b=%h",
                 tag, r, e, ix, data_a, blank_a, data_b);
    endtask

    // Plain-decoder expectation for dut_a.
    task automatic step_plain(input logic r, input logic e, input logic [2:0] ix,
                              input string tag);
        step(r, e, ix, r ? 8'h00 : (e ? onehot(ix) : 8'h00), 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        idx = 3'd0;

        // Reset overrides an enabled index.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, "reset");

`ifdef DECODER_3TO8_BLANK_EN
        // Enable rise with index 2: two blank cycles, then the line.
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, "rise_blank0");
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, "rise_blank1");
        step(1'b0, 1'b1, 3'd2, 8'h04, 1'b0, "rise_drive");
        step(1'b0, 1'b1, 3'd2, 8'h04, 1'b0, "hold_2");
        // 2 -> 3 break-before-make.
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b1, "chg23_blank0");
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b1, "chg23_blank1");
        step(1'b0, 1'b1, 3'd3, 8'h08, 1'b0, "chg23_drive");
        // Same index re-presented: no blank.
        step(1'b0, 1'b1, 3'd3, 8'h08, 1'b0, "same_idx");
        // Move to 1, then 3 -> 6 mid-blank restarts the counter.
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, "to1_blank0");
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, "to1_blank1");
        step(1'b0, 1'b1, 3'd1, 8'h02, 1'b0, "to1_drive");
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b1, "to3_blank0");
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b1, "restart6_blank0");
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b1, "restart6_blank1");
        step(1'b0, 1'b1, 3'd6, 8'h40, 1'b0, "restart6_drive");
        step(1'b0, 1'b1, 3'd6, 8'h40, 1'b0, "hold_6");
        // Enable fall from DRIVE.
        step(1'b0, 1'b0, 3'd6, 8'h00, 1'b0, "fall_drive");
        step(1'b0, 1'b0, 3'd6, 8'h00, 1'b0, "idle");
        // Reset in the middle of a blank, then re-enable with index 1.
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b1, "pre_rst_blank0");
        step(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, "rst_mid_blank");
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, "reen_blank0");
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, "reen_blank1");
        step(1'b0, 1'b1, 3'd1, 8'h02, 1'b0, "reen_drive");
        // Enable fall beats an index change during a blank.
        step(1'b0, 1'b1, 3'd7, 8'h00, 1'b1, "to7_blank0");
        step(1'b0, 1'b0, 3'd4, 8'h00, 1'b0, "fall_mid_blank");
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b1, "to4_blank0");
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b1, "to4_blank1");
        step(1'b0, 1'b1, 3'd4, 8'h10, 1'b0, "to4_drive");
`else
        // Sweep 0..7, one index per cycle.
        for (int i = 0; i < 8; i++) step_plain(1'b0, 1'b1, 3'(i), "sweep");
        step_plain(1'b0, 1'b0, 3'd7, "disable");
        step_plain(1'b0, 1'b1, 3'd3, "polarity_3");
        step_plain(1'b0, 1'b1, 3'd3, "hold_3");
        step_plain(1'b1, 1'b1, 3'd6, "reset_again");
        // Random enable/index traffic with occasional reset.
        for (int i = 0; i < 24; i++) begin
            logic       r_r;
            logic       r_e;
            logic [2:0] r_i;
            r_r = ($urandom_range(0, 9) == 0);
            r_e = 1'($urandom_range(0, 3) != 0);
            r_i = 3'($urandom_range(0, 7));
            step_plain(r_r, r_e, r_i, "random");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_sync.md
# decoder_3to8_sync

Registered 3-to-8 line decoder with enable, used as the row-select driver of the 8×8 RGB LED matrix scanner. It converts a 3-bit row index from the scan FSM into a one-hot row drive word. An optional break-before-make blanking interval prevents ghosting between adjacent rows. The module is named `decoder_3to8_sync`, and the scanner instantiates it directly on the row bus.

## Interface
Parameters:
- `ACTIVE_HIGH`, default 1: 1 means the selected line is driven 1 and the others 0. 0 inverts every output bit, so the selected line is 0 and the others 1.
- `BLANK_CYCLES`, default 2, legal range 0–255: number of all-inactive cycles inserted before a new line asserts. Used only when blanking is compiled in.

Ports:
- `clk_i`  in  1: system clock, 50 MHz. The one and only clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `data_3bit_i`  in  3: line index 0–7.
- `decoder_en_i`  in  1: decode enable. When low, all lines are inactive.
- `data_8bit_o`  out  8: registered one-hot line drive. Bit k corresponds to index k.
- `blank_o`  out  1: high while a blanking interval is in progress. Tied to 0 when blanking is compiled out.

## Operation
- Inactive word: 8'h00 when `ACTIVE_HIGH`=1; 8'hFF when `ACTIVE_HIGH`=0.
- Active word: bit `data_3bit_i` set and all other bits clear, inverted when `ACTIVE_HIGH`=0.
- Reset (`rst_i` sampled high at a clock edge):
  - `data_8bit_o` = inactive word.
  - `blank_o` = 0.
  - FSM goes to IDLE, blank counter = 0, stored index = 0.
  - Reset overrides all other inputs, including mid-blank.
- Blanking compiled out: on every clock edge, `data_8bit_o` <= `decoder_en_i` ? active word : inactive word.
- Blanking compiled in, FSM states IDLE, BLANK, DRIVE:
  - IDLE: outputs inactive.
    - `decoder_en_i`=1 → latch index. Go to BLANK if `BLANK_CYCLES`>0, else DRIVE.
  - BLANK: outputs inactive, `blank_o`=1, counter increments each cycle.
    - Counter reaches `BLANK_CYCLES`−1 → go to DRIVE and assert the stored index.
    - `decoder_en_i`=0 → go to IDLE.
    - Index change → latch the new index and restart the counter at 0.
  - DRIVE: outputs show the stored index, `blank_o`=0.
    - `decoder_en_i`=0 → go to IDLE, outputs inactive on the next edge.
    - Index change → latch it and go to BLANK (or stay in DRIVE with the new line if `BLANK_CYCLES`=0).
  - Same index re-presented: no blank, no glitch.
- Priority when events coincide: reset > enable low > index change > counter expiry.
- At most one line is active in any cycle. X/Z on the index while enabled is not required to be handled; implement a default branch that drives the inactive word.

## Timing
- Blanking compiled out: latency is 1 cycle from input sampled to output.
- Blanking compiled in:
  - Enable rise or index change sampled at edge N → outputs inactive for edges N+1 … N+`BLANK_CYCLES`.
  - The new line appears at edge N+1+`BLANK_CYCLES`.
  - `blank_o` is high over the same window.
- Enable fall: all lines are inactive from edge N+1 in both builds.
- With `BLANK_CYCLES`=0 the blanking build is cycle-identical to the non-blanking build.
- Outputs are driven only from flops; there is no combinational path from input to output.

## Configuration
- Macro `DECODER_3TO8_BLANK_EN`.
  - Defined: BLANK state, counter and `blank_o` logic are compiled in, giving break-before-make on every line change.
  - Undefined: pure registered decoder. `BLANK_CYCLES` is ignored and `blank_o` is constant 0.

## Test plan
- Reset: hold `rst_i`=1 with en=1 and index=5 → `data_8bit_o`=8'h00 and `blank_o`=0 (8'hFF with `ACTIVE_HIGH`=0).
- Sweep, blanking off: en=1, index 0..7, one per cycle → output 8'h01, 02, 04 … 80, each one cycle later. With en=0 → 8'h00 one cycle later.
- Polarity: `ACTIVE_HIGH`=0 with index=3 → 8'hF7.
- Blanking on, `BLANK_CYCLES`=2:
  - Index 2→3 at edge N → output 8'h04 through edge N, 8'h00 at N+1 and N+2, 8'h08 at N+3.
  - `blank_o` high at N+1 and N+2.
- Blanking on, index changes 3→6 during blank → counter restarts. Two inactive cycles follow the change, then 8'h40; 8'h08 never reappears.
- Blanking on, `rst_i` asserted during BLANK → next edge gives 8'h00, `blank_o`=0 and IDLE. Re-enable with index 1 → 8'h02 after 2 blank cycles.
